// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write-port arbiter between P5 write-back and buffered MDU results
//
// Purpose:
//   Shares the single register-file write port between the P5 write-back
//   stage and the out-of-band multiply/divide unit. MDU results are queued
//   in a small FIFO. P5 has priority. A pipeline freeze is requested when
//   the FIFO head has waited STARVE_LIMIT cycles or the FIFO is full.
//   A P5 write to register R kills every queued MDU result for R, including
//   one being pushed in the same cycle. The MDU instruction is older, so
//   its value must not overwrite the newer P5 value.
//
// Parameters:
//   FIFO_DEPTH    MDU result buffer entries (power of two, >= 2)
//   STARVE_LIMIT  cycles a valid head may wait before a stall (1..15)
//
// Optional build macro:
//   WBARB_PERF_EN  adds the o_stall_cycles and o_mdu_writes counters
//
// Ports:
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_p5_wr_en/i_p5_rd/i_p5_data  P5 write request
//   i_mdu_valid/i_mdu_rd/i_mdu_data, o_mdu_ready  MDU result push handshake
//   o_rf_wr_en/o_rf_wr_addr/o_rf_wr_data          registered RF write port
//   o_stall_req                   pipeline freeze request
//   o_stall_cycles, o_mdu_writes  performance counters (WBARB_PERF_EN only)

module wb_port_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_p5_wr_en,
  input  logic [4:0]  i_p5_rd,
  input  logic [31:0] i_p5_data,
  input  logic        i_mdu_valid,
  input  logic [4:0]  i_mdu_rd,
  input  logic [31:0] i_mdu_data,
  output logic        o_mdu_ready,
  output logic        o_rf_wr_en,
  output logic [4:0]  o_rf_wr_addr,
  output logic [31:0] o_rf_wr_data,
  output logic        o_stall_req
`ifdef WBARB_PERF_EN
  ,
  output logic [31:0] o_stall_cycles,
  output logic [31:0] o_mdu_writes
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [4:0]            rd_q   [FIFO_DEPTH];
  logic [31:0]           data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] live_q;
  logic [3:0]            wait_cnt;

  logic          fifo_empty;
  logic          fifo_full;
  logic          head_valid;
  logic [AW-1:0] head_idx;
  logic [AW-1:0] wr_idx;
  logic          push;
  logic          grant_p5;
  logic          grant_mdu;
  logic          head_write;
  logic          push_live;

  assign wr_idx     = wr_ptr[AW-1:0];
  assign head_idx   = rd_ptr[AW-1:0];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_valid = !fifo_empty;

  assign o_mdu_ready = !fifo_full;
  assign o_stall_req = head_valid && ((wait_cnt == STARVE_MAX) || fifo_full);

  assign push = i_mdu_valid && o_mdu_ready;

  // A stall blocks P5 entirely. While stalled, the head always wins. Otherwise
  // the head takes any slot that P5 leaves unused.
  assign grant_p5   = !o_stall_req && i_p5_wr_en && (i_p5_rd != 5'd0);
  assign grant_mdu  = head_valid && !grant_p5;
  assign head_write = grant_mdu && live_q[head_idx] && (rd_q[head_idx] != 5'd0);

  // An entry pushed alongside a P5 write to the same register is born dead.
  assign push_live = !(grant_p5 && (i_mdu_rd == i_p5_rd));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      live_q       <= '0;
      wait_cnt     <= 4'd0;
      o_rf_wr_en   <= 1'b0;
      o_rf_wr_addr <= 5'd0;
      o_rf_wr_data <= 32'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (grant_mdu) rd_ptr <= rd_ptr + 1'b1;

      if (grant_p5) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          if (rd_q[i] == i_p5_rd) live_q[i] <= 1'b0;
        end
      end
      if (push) live_q[wr_idx] <= push_live;

      if (grant_mdu || fifo_empty) wait_cnt <= 4'd0;
      else if (wait_cnt != STARVE_MAX) wait_cnt <= wait_cnt + 4'd1;

      o_rf_wr_en <= grant_p5 || head_write;
      if (grant_p5) begin
        o_rf_wr_addr <= i_p5_rd;
        o_rf_wr_data <= i_p5_data;
      end else if (grant_mdu) begin
        o_rf_wr_addr <= rd_q[head_idx];
        o_rf_wr_data <= data_q[head_idx];
      end
    end
  end

  // Payload storage needs no reset. Only live bits and pointers define occupancy.
  always_ff @(posedge i_clk) begin
    if (push) begin
      rd_q[wr_idx]   <= i_mdu_rd;
      data_q[wr_idx] <= i_mdu_data;
    end
  end

`ifdef WBARB_PERF_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_stall_cycles <= 32'd0;
      o_mdu_writes   <= 32'd0;
    end else begin
      if (o_stall_req) o_stall_cycles <= o_stall_cycles + 32'd1;
      if (head_write)  o_mdu_writes   <= o_mdu_writes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed self-checking bench for wb_port_arbiter

module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        p5_wr_en;
  logic [4:0]  p5_rd;
  logic [31:0] p5_data;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        stall_req;
`ifdef WBARB_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] mdu_writes;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  wb_port_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_p5_wr_en   (p5_wr_en),
    .i_p5_rd      (p5_rd),
    .i_p5_data    (p5_data),
    .i_mdu_valid  (mdu_valid),
    .i_mdu_rd     (mdu_rd),
    .i_mdu_data   (mdu_data),
    .o_mdu_ready  (mdu_ready),
    .o_rf_wr_en   (rf_wr_en),
    .o_rf_wr_addr (rf_wr_addr),
    .o_rf_wr_data (rf_wr_data),
    .o_stall_req  (stall_req)
`ifdef WBARB_PERF_EN
    ,
    .o_stall_cycles (stall_cycles),
    .o_mdu_writes   (mdu_writes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    p5_wr_en  = 1'b0;
    p5_rd     = 5'd0;
    p5_data   = 32'd0;
    mdu_valid = 1'b0;
    mdu_rd    = 5'd0;
    mdu_data  = 32'd0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_tests++;
    if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_rf: got en=%0b addr=%0d data=%h, want all 0", rf_wr_en, rf_wr_addr, rf_wr_data);
    end
    n_tests++;
    if (mdu_ready !== 1'b1 || stall_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got ready=%0b stall=%0b, want ready=1 stall=0", mdu_ready, stall_req);
    end
  endtask

  task automatic test_p5_only;
    p5_wr_en = 1'b1; p5_rd = 5'd5; p5_data = 32'hDEADBEEF;
    tick();
    n_tests++;
    if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd5 || rf_wr_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL p5_write: got en=%0b addr=%0d data=%h, want 1/5/deadbeef", rf_wr_en, rf_wr_addr, rf_wr_data);
    end
    p5_rd = 5'd0; p5_data = 32'h11111111;
    tick();
    n_tests++;
    if (rf_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL p5_x0: got en=%0b, want 0", rf_wr_en);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_idle_mdu;
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h12345678;
    tick();
    idle_inputs();
    n_tests++;
    if (rf_wr_en !== 1'b0 || stall_req !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_push: got en=%0b stall=%0b, want 0/0", rf_wr_en, stall_req);
    end
    tick();
    n_tests++;
    if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd7 || rf_wr_data !== 32'h12345678 || stall_req !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_write: got en=%0b addr=%0d data=%h stall=%0b, want 1/7/12345678/0",
               rf_wr_en, rf_wr_addr, rf_wr_data, stall_req);
    end
    tick();
  endtask

  task automatic test_starvation;
    p5_wr_en = 1'b1; p5_rd = 5'd3; p5_data = 32'h00000033;
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h00000099;
    tick();
    mdu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (stall_req !== 1'b0 || rf_wr_addr !== 5'd3) begin
        n_fail++;
        $display("FAIL starve_wait%0d: got stall=%0b addr=%0d, want 0/3", i, stall_req, rf_wr_addr);
      end
      tick();
    end
    n_tests++;
    if (stall_req !== 1'b1) begin
      n_fail++;
      $display("FAIL starve_stall: got stall=%0b, want 1", stall_req);
    end
    tick();
    n_tests++;
    if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd9 || rf_wr_data !== 32'h99 || stall_req !== 1'b0) begin
      n_fail++;
      $display("FAIL starve_mdu: got en=%0b addr=%0d data=%h stall=%0b, want 1/9/99/0",
               rf_wr_en, rf_wr_addr, rf_wr_data, stall_req);
    end
    tick();
    n_tests++;
    if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd3 || rf_wr_data !== 32'h33) begin
      n_fail++;
      $display("FAIL starve_p5: got en=%0b addr=%0d data=%h, want 1/3/33", rf_wr_en, rf_wr_addr, rf_wr_data);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_full;
    p5_wr_en = 1'b1; p5_rd = 5'd3; p5_data = 32'h30;
    mdu_valid = 1'b1; mdu_rd = 5'd10; mdu_data = 32'hA0;
    tick();
    mdu_rd = 5'd11; mdu_data = 32'hB0;
    tick();
    n_tests++;
    if (mdu_ready !== 1'b0 || stall_req !== 1'b1) begin
      n_fail++;
      $display("FAIL full_flags: got ready=%0b stall=%0b, want 0/1", mdu_ready, stall_req);
    end
    mdu_rd = 5'd12; mdu_data = 32'hC0;
    tick();
    n_tests++;
    if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd10 || rf_wr_data !== 32'hA0 || mdu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_pop: got en=%0b addr=%0d data=%h ready=%0b, want 1/10/a0/1",
               rf_wr_en, rf_wr_addr, rf_wr_data, mdu_ready);
    end
    tick();
    n_tests++;
    if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd3) begin
      n_fail++;
      $display("FAIL full_p5: got en=%0b addr=%0d, want 1/3", rf_wr_en, rf_wr_addr);
    end
    idle_inputs();
    tick();
    n_tests++;
    if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd11 || rf_wr_data !== 32'hB0) begin
      n_fail++;
      $display("FAIL full_drain1: got en=%0b addr=%0d data=%h, want 1/11/b0", rf_wr_en, rf_wr_addr, rf_wr_data);
    end
    tick();
    n_tests++;
    if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd12 || rf_wr_data !== 32'hC0) begin
      n_fail++;
      $display("FAIL full_drain2: got en=%0b addr=%0d data=%h, want 1/12/c0", rf_wr_en, rf_wr_addr, rf_wr_data);
    end
    tick();
    n_tests++;
    if (rf_wr_en !== 1'b0 || mdu_ready !== 1'b1 || stall_req !== 1'b0) begin
      n_fail++;
      $display("FAIL full_empty: got en=%0b ready=%0b stall=%0b, want 0/1/0", rf_wr_en, mdu_ready, stall_req);
    end
  endtask

  task automatic test_stale_kill;
    p5_wr_en = 1'b1; p5_rd = 5'd3; p5_data = 32'h3;
    mdu_valid = 1'b1; mdu_rd = 5'd4; mdu_data = 32'hAAAA;
    tick();
    mdu_valid = 1'b0;
    p5_rd = 5'd4; p5_data = 32'hBBBB;
    tick();
    n_tests++;
    if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd4 || rf_wr_data !== 32'hBBBB) begin
      n_fail++;
      $display("FAIL kill_p5: got en=%0b addr=%0d data=%h, want 1/4/bbbb", rf_wr_en, rf_wr_addr, rf_wr_data);
    end
    idle_inputs();
    tick();
    n_tests++;
    if (rf_wr_en !== 1'b0 || mdu_ready !== 1'b1 || stall_req !== 1'b0) begin
      n_fail++;
      $display("FAIL kill_dead_pop: got en=%0b ready=%0b stall=%0b, want 0/1/0", rf_wr_en, mdu_ready, stall_req);
    end
    // Same-cycle push and P5 write to one register: the pushed entry is born dead.
    p5_wr_en = 1'b1; p5_rd = 5'd6; p5_data = 32'h66;
    mdu_valid = 1'b1; mdu_rd = 5'd6; mdu_data = 32'h77;
    tick();
    idle_inputs();
    n_tests++;
    if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd6 || rf_wr_data !== 32'h66) begin
      n_fail++;
      $display("FAIL kill_same_p5: got en=%0b addr=%0d data=%h, want 1/6/66", rf_wr_en, rf_wr_addr, rf_wr_data);
    end
    tick();
    n_tests++;
    if (rf_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL kill_same_pop: got en=%0b, want 0", rf_wr_en);
    end
    tick();
    n_tests++;
    if (rf_wr_en !== 1'b0 || mdu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL kill_same_empty: got en=%0b ready=%0b, want 0/1", rf_wr_en, mdu_ready);
    end
`ifdef WBARB_PERF_EN
    // MDU port writes so far: 7, 9, 10, 11, 12. Stall cycles: one in starvation, one when full.
    n_tests++;
    if (mdu_writes !== 32'd5 || stall_cycles !== 32'd2) begin
      n_fail++;
      $display("FAIL perf_counts: got writes=%0d stalls=%0d, want 5/2", mdu_writes, stall_cycles);
    end
`endif
  endtask

  task automatic test_reset_midstream;
    p5_wr_en = 1'b1; p5_rd = 5'd3; p5_data = 32'h3C3C3C3C;
    mdu_valid = 1'b1; mdu_rd = 5'd13; mdu_data = 32'hD0;
    tick();
    mdu_rd = 5'd14; mdu_data = 32'hE0;
    tick();
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== 38'd0 || mdu_ready !== 1'b1 || stall_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: got en=%0b addr=%0d data=%h ready=%0b stall=%0b, want 0/0/0/1/0",
               rf_wr_en, rf_wr_addr, rf_wr_data, mdu_ready, stall_req);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (rf_wr_en !== 1'b0 || stall_req !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_no_write%0d: got en=%0b stall=%0b, want 0/0", i, rf_wr_en, stall_req);
      end
    end
`ifdef WBARB_PERF_EN
    n_tests++;
    if (mdu_writes !== 32'd0 || stall_cycles !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_perf: got writes=%0d stalls=%0d, want 0/0", mdu_writes, stall_cycles);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_p5_only();
    test_idle_mdu();
    test_starvation();
    test_full();
    test_stale_kill();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
